// File: rtl/mem_seq.sv
// Command sequencer that owns the write port of a 2**ADDR_W x DATA_W RAM.
// Executes WRITE / READ / CLEAR / NOP commands and returns read data as a one-cycle pulse.
module mem_seq #(
  parameter int                ADDR_W    = 4,
  parameter int                DATA_W    = 4,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              mem_load,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_WRITE = 2'b01,
    S_READ  = 2'b10,
    S_CLEAR = 2'b11
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_in_q, mem_in_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

  // Decoded straight from the state flop so reset drops load/raises ready without a clock.
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = ~cmd_ready;
  assign mem_load  = (state_q == S_WRITE) || (state_q == S_CLEAR);
  assign mem_addr  = mem_addr_q;
  assign mem_in    = mem_in_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_in_d    = mem_in_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_WRITE: begin
              mem_addr_d = cmd_addr;
              mem_in_d   = cmd_data;
              state_d    = S_WRITE;
            end
            OP_READ: begin
              mem_addr_d = cmd_addr;
              state_d    = S_READ;
            end
            OP_CLEAR: begin
              mem_addr_d = '0;
              mem_in_d   = CLEAR_VAL;
              state_d    = S_CLEAR;
            end
            default: ;
          endcase
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_READ: begin
        // mem_q has had a full cycle to settle on the address captured at accept.
        rsp_data_d  = mem_q;
        rsp_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      S_CLEAR: begin
        if (mem_addr_q == LAST_ADDR) begin
          mem_addr_d = '0;
          state_d    = S_IDLE;
        end else begin
          mem_addr_d = mem_addr_q + ADDR_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      mem_addr_q  <= '0;
      mem_in_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_in_q    <= mem_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule
